// File: rtl/depthwise_simd_accum.sv
// Depthwise SIMD multiply-accumulate array.
// NUM_PE lanes each accumulate signed DATA_WIDTH x DATA_WIDTH products over a
// KERNEL_TAPS-beat window. Completed windows go to a registered result stream
// that the consumer can hold off with out_ready.
// Optional feature: define DW_SIMD_RELU_EN to clamp negative lane results to 0
// before they are registered. The accumulators never see the clamp.

module depthwise_simd_accum #(
    parameter int unsigned NUM_PE         = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned OUT_DATA_WIDTH = 32,
    parameter int unsigned KERNEL_TAPS    = 9
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     Kernel,
    input  logic [NUM_PE*DATA_WIDTH-1:0]     Input_Act,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_PE*OUT_DATA_WIDTH-1:0] Result,
    output logic                             busy
);

    localparam int unsigned TapW = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
    localparam logic [TapW-1:0] LastTap = TapW'(KERNEL_TAPS - 1);

    logic [TapW-1:0]                        tap_cnt_q, tap_cnt_d;
    logic [NUM_PE-1:0][OUT_DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [NUM_PE-1:0][OUT_DATA_WIDTH-1:0]  result_q, result_d;
    logic                                   out_valid_q, out_valid_d;

    logic [NUM_PE-1:0][OUT_DATA_WIDTH-1:0]  sum;
    logic [NUM_PE-1:0][OUT_DATA_WIDTH-1:0]  lane_res;
    logic                                   last_tap;
    logic                                   accept;

    // Per-lane signed product, sign-extended and added to the running sum.
    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]     k_s;
        logic signed [DATA_WIDTH-1:0]     a_s;
        logic signed [2*DATA_WIDTH-1:0]   prod;
        logic signed [OUT_DATA_WIDTH-1:0] prod_ext;

        assign k_s      = Kernel[i*DATA_WIDTH +: DATA_WIDTH];
        assign a_s      = Input_Act[i*DATA_WIDTH +: DATA_WIDTH];
        assign prod     = (2*DATA_WIDTH)'(k_s) * (2*DATA_WIDTH)'(a_s);
        assign prod_ext = OUT_DATA_WIDTH'(prod);
        assign sum[i]   = acc_q[i] + prod_ext;
`ifdef DW_SIMD_RELU_EN
        assign lane_res[i] = sum[i][OUT_DATA_WIDTH-1] ? '0 : sum[i];
`else
        assign lane_res[i] = sum[i];
`endif
    end

    assign last_tap = (tap_cnt_q == LastTap);
    // Only the closing tap needs a free output slot; earlier taps keep flowing.
    assign in_ready = !reset && !clear && !(out_valid_q && !out_ready && last_tap);
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign busy      = (tap_cnt_q != '0);

    // Next-state: output drain, then clear or accepted beat (clear wins).
    always_comb begin
        acc_d       = acc_q;
        tap_cnt_d   = tap_cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            acc_d     = '0;
            tap_cnt_d = '0;
        end else if (accept) begin
            if (last_tap) begin
                // Closing tap overrides a same-cycle drain: back-to-back windows.
                result_d    = lane_res;
                out_valid_d = 1'b1;
                acc_d       = '0;
                tap_cnt_d   = '0;
            end else begin
                acc_d     = sum;
                tap_cnt_d = tap_cnt_q + TapW'(1);
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            tap_cnt_q   <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            tap_cnt_q   <= tap_cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_depthwise_simd_accum.sv
// Testbench for depthwise_simd_accum: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// window-level reference model kept in the bench.

module tb_depthwise_simd_accum;

    localparam int NPE  = 16;
    localparam int DW   = 8;
    localparam int ODW  = 32;
    localparam int TAPS = 9;

    logic                 clk = 1'b0;
    logic                 reset, clear, in_valid, out_ready;
    logic                 in_ready, out_valid, busy;
    logic [NPE*DW-1:0]    Kernel, Input_Act;
    logic [NPE*ODW-1:0]   Result;

    int total = 0;
    int bad   = 0;

    depthwise_simd_accum #(
        .NUM_PE        (NPE),
        .DATA_WIDTH    (DW),
        .OUT_DATA_WIDTH(ODW),
        .KERNEL_TAPS   (TAPS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Kernel   (Kernel),
        .Input_Act(Input_Act),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result   (Result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Window-level view: running lane sums, beats taken so far, held result.
    int          m_sum [NPE];
    int          m_res [NPE];
    int          m_beats;
    bit          m_ov;
    bit          model_ok = 1'b0;

    function automatic int relu(input int v);
`ifdef DW_SIMD_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int lane_prod(input int i);
        logic signed [DW-1:0] k, a;
        k = Kernel[i*DW +: DW];
        a = Input_Act[i*DW +: DW];
        return int'(k) * int'(a);
    endfunction

    // Compare DUT against model at the falling edge, then advance the model.
    always @(negedge clk) begin
        bit                 exp_ir;
        logic [NPE*ODW-1:0] exp_res;
        exp_ir = !reset && !clear && !(m_ov && !out_ready && m_beats == TAPS - 1);
        for (int i = 0; i < NPE; i++) exp_res[i*ODW +: ODW] = m_res[i];
        if (model_ok) begin
            total++;
            if (out_valid !== m_ov) begin
                bad++;
                $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, m_ov);
            end
            total++;
            if (busy !== (m_beats != 0)) begin
                bad++;
                $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, m_beats != 0);
            end
            total++;
            if (in_ready !== exp_ir) begin
                bad++;
                $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ir);
            end
            total++;
            if (Result !== exp_res) begin
                bad++;
                $display("FAIL result t=%0t got=%h exp=%h", $time, Result, exp_res);
            end
        end
        if (reset) begin
            for (int i = 0; i < NPE; i++) begin
                m_sum[i] = 0;
                m_res[i] = 0;
            end
            m_beats  = 0;
            m_ov     = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (m_ov && out_ready) m_ov = 1'b0;
            if (clear) begin
                for (int i = 0; i < NPE; i++) m_sum[i] = 0;
                m_beats = 0;
            end else if (in_valid && exp_ir) begin
                for (int i = 0; i < NPE; i++) m_sum[i] += lane_prod(i);
                m_beats++;
                if (m_beats == TAPS) begin
                    for (int i = 0; i < NPE; i++) begin
                        m_res[i] = relu(m_sum[i]);
                        m_sum[i] = 0;
                    end
                    m_ov    = 1'b1;
                    m_beats = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return Result[i*ODW +: ODW];
    endfunction

    task automatic set_all(input logic [DW-1:0] k, input logic [DW-1:0] a);
        for (int i = 0; i < NPE; i++) begin
            Kernel[i*DW +: DW]    = k;
            Input_Act[i*DW +: DW] = a;
        end
    endtask

    task automatic beats(input int n);
        in_valid = 1'b1;
        for (int b = 0; b < n; b++) tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Kernel = '0; Input_Act = '0;
        tick();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_result", lane(0), 32'd0);

        // Basic window
        set_all(8'd2, 8'd3);
        in_valid = 1'b1;
        for (int b = 0; b < TAPS; b++) begin
            if (b > 0) chk("basic_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("basic_ov", {31'd0, out_valid}, 32'd1);
        chk("basic_lane0", lane(0), 32'd54);
        chk("basic_lane15", lane(15), 32'd54);
        chk("basic_busy_end", {31'd0, busy}, 32'd0);
        tick();
        chk("basic_ov_drop", {31'd0, out_valid}, 32'd0);

        // Signed extreme
        set_all(8'd0, 8'd0);
        Kernel[7:0] = 8'h80; Input_Act[7:0] = 8'h7f;
        Kernel[15:8] = 8'hff; Input_Act[15:8] = 8'hff;
        beats(TAPS);
`ifdef DW_SIMD_RELU_EN
        chk("extreme_lane0", lane(0), 32'd0);
`else
        chk("extreme_lane0", lane(0), 32'hFFFDC480);
`endif
        chk("extreme_lane1", lane(1), 32'd9);
        tick();

        // Backpressure
        out_ready = 1'b0;
        set_all(8'd2, 8'd3);
        beats(TAPS);
        chk("bp_w1", lane(3), 32'd54);
        set_all(8'd1, 8'd1);
        beats(TAPS - 1);
        in_valid = 1'b1;
        #1;
        chk("bp_stall", {31'd0, in_ready}, 32'd0);
        tick(); tick();
        chk("bp_hold", lane(3), 32'd54);
        chk("bp_hold_ov", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_b2b_ov", {31'd0, out_valid}, 32'd1);
        chk("bp_w2", lane(3), 32'd9);
        tick();
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // Gaps and clear
        set_all(8'd5, 8'd5);
        beats(4);
        in_valid = 1'b1; clear = 1'b1;
        #1;
        chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd0);
        set_all(8'd1, 8'd2);
        for (int b = 0; b < TAPS; b++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (b < TAPS - 1) tick();
        end
        chk("gaps_lane7", lane(7), 32'd18);
        chk("gaps_ov", {31'd0, out_valid}, 32'd1);

        // Reset mid-window with a held result
        out_ready = 1'b0;
        set_all(8'd2, 8'd3);
        beats(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", lane(7), 32'd0);
        out_ready = 1'b1;
        beats(TAPS);
        chk("rst_window", lane(9), 32'd54);
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NPE; i++) begin
                Kernel[i*DW +: DW]    = DW'($urandom);
                Input_Act[i*DW +: DW] = DW'($urandom);
            end
            tick();
        end
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
